// File: rtl/halflife_pkg.sv
// Shared types and defaults for the half-life timer sequencer.
// Optional event counter in halflife_ctrl is enabled by HALFLIFE_EVENT_CNT_EN.
package halflife_pkg;

  localparam int N_DEFAULT      = 4;
  localparam int PERIOD_DEFAULT = 16;

  typedef logic [N_DEFAULT-1:0] count_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    HALVE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/halflife_prescaler.sv
// Decay-period prescaler: counts 0..PERIOD-1 while enabled, wraps explicitly.
module halflife_prescaler #(
  parameter int PERIOD = 16,
  parameter int PW     = $clog2(PERIOD)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [PW-1:0] cnt_reg;

  assign tc = (cnt_reg == PW'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tc ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/halflife_ctrl.sv
// Half-life sequencer: loads the counter, then halves it every PERIOD cycles.
// Define HALFLIFE_EVENT_CNT_EN to add the saturating 'events' halving counter.
module halflife_ctrl
  import halflife_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int PERIOD = PERIOD_DEFAULT,
  localparam int PW    = $clog2(PERIOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] init_val,
  input  logic [N-1:0] count,
  output logic         cnt_up,
  output logic         cnt_down,
  output logic         cnt_load,
  output logic [N-1:0] cnt_in,
  output logic         busy,
  output logic         halving,
  output logic         done
`ifdef HALFLIFE_EVENT_CNT_EN
  ,
  output logic [N-1:0] events
`endif
);

  state_t       state_reg;
  logic [N-1:0] target_reg;
  logic [N-1:0] cnt_in_reg;
  logic         pre_clr;
  logic         pre_en;
  logic         pre_tc;
  logic         accept;
  logic         halve_exit;

  assign accept     = start && !abort && (state_reg == IDLE || state_reg == DONE);
  assign halve_exit = !abort && (state_reg == HALVE) && (count <= target_reg);

  // Prescaler only runs in WAIT while there is something left to halve.
  assign pre_clr = (state_reg != WAIT);
  assign pre_en  = (state_reg == WAIT) && (count != '0);

  halflife_prescaler #(
    .PERIOD(PERIOD),
    .PW    (PW)
  ) u_prescaler (
    .clk(clk),
    .rst(rst),
    .clr(pre_clr),
    .en (pre_en),
    .tc (pre_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      target_reg <= '0;
      cnt_in_reg <= '0;
    end else if (abort) begin
      state_reg  <= IDLE;
      cnt_in_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            cnt_in_reg <= init_val;
            state_reg  <= LOAD;
          end
        end
        LOAD: state_reg <= WAIT;
        WAIT: begin
          if (count == '0) begin
            state_reg <= DONE;
          end else if (pre_tc) begin
            target_reg <= count >> 1;
            state_reg  <= HALVE;
          end
        end
        HALVE: begin
          // Also covers an external drop below target: leave without decrementing.
          if (count <= target_reg) begin
            state_reg <= (count == '0) ? DONE : WAIT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cnt_up   = 1'b0;
  assign cnt_load = (state_reg == LOAD);
  assign cnt_down = (state_reg == HALVE) && (count > target_reg);
  assign cnt_in   = cnt_in_reg;
  assign busy     = (state_reg == LOAD) || (state_reg == WAIT) || (state_reg == HALVE);
  assign halving  = (state_reg == HALVE);
  assign done     = (state_reg == DONE);

`ifdef HALFLIFE_EVENT_CNT_EN
  logic [N-1:0] events_reg;

  // Cleared on the accepting edge so it already reads zero during LOAD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      events_reg <= '0;
    end else if (accept) begin
      events_reg <= '0;
    end else if (halve_exit && (events_reg != '1)) begin
      events_reg <= events_reg + 1'b1;
    end
  end

  assign events = events_reg;
`else
  logic unused_ok;
  assign unused_ok = accept ^ halve_exit;
`endif

endmodule

// File: tb/tb_halflife_ctrl.sv
// Self-checking bench for halflife_ctrl with a behavioural 4-bit counter attached.
module tb_halflife_ctrl;
  import halflife_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] init_val = '0;
  count_t     count = '0;
  logic       cnt_up, cnt_down, cnt_load, busy, halving, done;
  logic [3:0] cnt_in;
`ifdef HALFLIFE_EVENT_CNT_EN
  logic [3:0] events;
`endif

  logic       ext_set = 1'b0;
  logic [3:0] ext_val = '0;

  int errors = 0;
  int checks = 0;

  int         exp_pulse_q[$];
  logic [3:0] exp_count_q[$];

  always #5 clk = ~clk;

  halflife_ctrl #(.N(4), .PERIOD(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .init_val(init_val), .count(count),
    .cnt_up(cnt_up), .cnt_down(cnt_down), .cnt_load(cnt_load), .cnt_in(cnt_in),
    .busy(busy), .halving(halving), .done(done)
`ifdef HALFLIFE_EVENT_CNT_EN
    , .events(events)
`endif
  );

  // Counter model; ext_set models an external write that beats the DUT commands.
  always @(posedge clk) begin
    if (ext_set)       count <= ext_val;
    else if (cnt_load) count <= cnt_in;
    else if (cnt_up)   count <= count + 1'b1;
    else if (cnt_down) count <= count - 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ((int'(cnt_up) + int'(cnt_down) + int'(cnt_load)) > 1 || cnt_up !== 1'b0) begin
        errors++;
        $display("FAIL onehot: up=%b down=%b load=%b at %0t", cnt_up, cnt_down, cnt_load, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halving(output bit ok);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (halving === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_halving: halving=%b required 1 within 100 cycles", halving); end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; init_val = 4'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({cnt_load, cnt_down, busy, halving, done, cnt_in} !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs: load=%b down=%b busy=%b halving=%b done=%b cnt_in=%0d required all 0",
                 cnt_load, cnt_down, busy, halving, done, cnt_in);
      end
    end
    rst = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (cnt_load !== 1'b1 || cnt_in !== 4'd9) begin
      errors++;
      $display("FAIL reset_release_start: load=%b cnt_in=%0d required load=1 cnt_in=9", cnt_load, cnt_in);
    end
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cnt_in !== 4'd0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b cnt_in=%0d required 0 0", busy, cnt_in);
    end
    $display("txn reset: done");
  endtask

  task automatic test_zero();
    int downs = 0;
    init_val = 4'd0; start = 1'b1; step(); start = 1'b0;
    checks++;
    if (cnt_load !== 1'b1) begin errors++; $display("FAIL zero_load: load=%b required 1", cnt_load); end
    step(); if (cnt_down) downs++;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL zero_wait: busy=%b done=%b required 1 0", busy, done);
    end
    step(); if (cnt_down) downs++;
    checks++;
    if (done !== 1'b1 || downs != 0) begin
      errors++; $display("FAIL zero_done: done=%b downs=%0d required 1 0", done, downs);
    end
    $display("txn zero: done=%b downs=%0d", done, downs);
  endtask

  task automatic test_full_run(input bit restart);
    int  loads, downs;
    bit  prev_h, fin;
    int  ep;
    logic [3:0] ec;
    exp_pulse_q = {};
    exp_count_q = {};
    exp_pulse_q.push_back(6); exp_count_q.push_back(4'd6);
    exp_pulse_q.push_back(3); exp_count_q.push_back(4'd3);
    exp_pulse_q.push_back(2); exp_count_q.push_back(4'd1);
    exp_pulse_q.push_back(1); exp_count_q.push_back(4'd0);
    init_val = 4'd12; start = 1'b1; step(); start = 1'b0;
    checks++;
    if (cnt_load !== 1'b1) begin errors++; $display("FAIL run_load: load=%b required 1", cnt_load); end
`ifdef HALFLIFE_EVENT_CNT_EN
    if (restart) begin
      checks++;
      if (events !== 4'd0) begin errors++; $display("FAIL events_clear: events=%0d required 0", events); end
    end
`endif
    loads = 1; downs = 0; prev_h = 0; fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      step();
      if (cnt_load) loads++;
      if (cnt_down) downs++;
      if (prev_h && !halving) begin
        checks++;
        if (exp_pulse_q.size() == 0) begin
          errors++; $display("FAIL run_extra_halving: count=%0d required no further halving", count);
        end else begin
          ep = exp_pulse_q.pop_front();
          ec = exp_count_q.pop_front();
          if (downs != ep || count !== ec) begin
            errors++;
            $display("FAIL run_halving: downs=%0d count=%0d required downs=%0d count=%0d", downs, count, ep, ec);
          end
          $display("txn halving: downs=%0d count=%0d", downs, count);
        end
        downs = 0;
      end
      prev_h = halving;
      if (done) fin = 1;
    end
    checks++;
    if (!fin || exp_pulse_q.size() != 0 || loads != 1 || count !== 4'd0) begin
      errors++;
      $display("FAIL run_end: done=%b pending=%0d loads=%0d count=%0d required 1 0 1 0",
               fin, exp_pulse_q.size(), loads, count);
    end
`ifdef HALFLIFE_EVENT_CNT_EN
    checks++;
    if (events !== 4'd4) begin errors++; $display("FAIL events_count: events=%0d required 4", events); end
`endif
    $display("txn full_run restart=%0d: done=%b", restart, done);
  endtask

  task automatic test_start_in_wait();
    init_val = 4'd12; start = 1'b1; step(); start = 1'b0;
    step();
    init_val = 4'd5; start = 1'b1;
    step(); step();
    start = 1'b0;
    checks++;
    if (cnt_in !== 4'd12 || busy !== 1'b1 || cnt_load !== 1'b0) begin
      errors++;
      $display("FAIL start_in_wait: cnt_in=%0d busy=%b load=%b required 12 1 0", cnt_in, busy, cnt_load);
    end
    abort = 1'b1; step(); abort = 1'b0;
    $display("txn start_in_wait: cnt_in ignored");
  endtask

  task automatic test_start_abort_idle();
    init_val = 4'd7; start = 1'b1; abort = 1'b1;
    step(); step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cnt_load !== 1'b0 || cnt_in !== 4'd0) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b load=%b cnt_in=%0d required 0 0 0", busy, cnt_load, cnt_in);
    end
    $display("txn start_abort_idle: busy=%b", busy);
  endtask

  task automatic test_abort_halve();
    bit ok;
    init_val = 4'd15; start = 1'b1; step(); start = 1'b0;
    wait_halving(ok);
    if (!ok) return;
    step();
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (cnt_down !== 1'b0 || busy !== 1'b0 || halving !== 1'b0 || done !== 1'b0 || count !== 4'd13) begin
      errors++;
      $display("FAIL abort_halve: down=%b busy=%b halving=%b done=%b count=%0d required 0 0 0 0 13",
               cnt_down, busy, halving, done, count);
    end
    step(); step();
    checks++;
    if (count !== 4'd13) begin errors++; $display("FAIL abort_hold: count=%0d required 13", count); end
    $display("txn abort_halve: count=%0d", count);
  endtask

  task automatic test_ext_drop();
    bit ok;
    init_val = 4'd15; start = 1'b1; step(); start = 1'b0;
    wait_halving(ok);
    if (!ok) return;
    ext_set = 1'b1; ext_val = 4'd3; step(); ext_set = 1'b0;
    checks++;
    if (cnt_down !== 1'b0 || halving !== 1'b1 || count !== 4'd3) begin
      errors++;
      $display("FAIL ext_drop_halve: down=%b halving=%b count=%0d required 0 1 3", cnt_down, halving, count);
    end
    step();
    checks++;
    if (halving !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || count !== 4'd3) begin
      errors++;
      $display("FAIL ext_drop_exit: halving=%b busy=%b done=%b count=%0d required 0 1 0 3",
               halving, busy, done, count);
    end
    abort = 1'b1; step(); abort = 1'b0;
    $display("txn ext_drop: count=%0d", count);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_full_run(1'b0);
    test_full_run(1'b1);
    test_start_in_wait();
    test_start_abort_idle();
    test_abort_halve();
    test_ext_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/halflife_ctrl.md
Name: halflife_ctrl

Overview:
Sequencer for the team's 4-bit up/down/load counter in the half-life timer. On start it loads an initial value into the counter, then after every decay period it halves the counter value by issuing single-cycle decrement commands. It uses the counter's output as feedback and stops when the count reaches zero. It sits between the top-level control pins and the counter instance, and owns that counter's up/down/load/in inputs.

Parameters:
N, 4, counter width; must match the counter instance.
PERIOD, 16, clock cycles spent in WAIT before each halving; legal values are PERIOD >= 2.
PW, $clog2(PERIOD), prescaler width; derived, not overridden.

Ports:
clk  input  1  single clock, all state updates on the rising edge.
rst  input  1  synchronous, active-low reset.
start  input  1  level-sampled request to begin a decay run.
abort  input  1  returns the block to IDLE from any state.
init_val  input  N  initial count, sampled when start is accepted.
count  input  N  current output of the counter (feedback).
cnt_up  output  1  counter up command; tied 0 in this block.
cnt_down  output  1  counter down command.
cnt_load  output  1  counter load command.
cnt_in  output  N  load value; the registered copy of init_val.
busy  output  1  high in LOAD, WAIT and HALVE.
halving  output  1  high in HALVE.
done  output  1  high in DONE.

Behaviour:
- Reset (rst==0 at an edge): state goes to IDLE, prescaler=0, target=0, cnt_in=0.
  - All outputs are 0 during and after reset until the next start.
- Command outputs are Moore-decoded from the state and registers.
  - At most one of cnt_up, cnt_down, cnt_load is high in any cycle.
- IDLE:
  - start=1 and abort=0: latch init_val into cnt_in, go to LOAD.
- LOAD (exactly 1 cycle):
  - cnt_load=1. Counter shows cnt_in on the following cycle.
  - Next state is WAIT; prescaler cleared.
- WAIT:
  - If count==0, go to DONE. This check has priority over the prescaler.
  - Otherwise the prescaler increments each cycle.
  - When prescaler==PERIOD-1: target <= count>>1 (logical shift, floor), prescaler <= 0, go to HALVE.
- HALVE:
  - cnt_down = (count > target).
  - When count <= target: go to DONE if count==0, else go to WAIT.
  - Halving k to floor(k/2) takes k-floor(k/2) decrement cycles plus 1 exit cycle.
- DONE:
  - done=1, held indefinitely.
  - start=1 restarts the run (latch init_val, go to LOAD).
- abort=1 in any state: go to IDLE next edge; outputs are 0 from that edge.
  - abort beats start when both are asserted.
  - abort in IDLE has no effect.
- start while busy is ignored; no queuing.
- init_val==0: LOAD, then WAIT sees count==0 and goes to DONE. No down pulses are issued.
- count changed externally below target during HALVE: exit HALVE without issuing cnt_down. The block never underflows the counter.
- Prescaler never exceeds PERIOD-1; its wrap is explicit, not a natural overflow.

Optional Feature:
Macro HALFLIFE_EVENT_CNT_EN.
- Defined: adds output port events (width N). It counts completed halvings, i.e. HALVE→WAIT or HALVE→DONE exits.
  - Cleared on reset and in LOAD.
  - Saturates at all-ones.
  - Holds its value in DONE and IDLE.
- Undefined: no port and no counter register; all other behaviour is identical.

Decomposition:
- Package halflife_pkg holds:
  - the state enum typedef (IDLE, LOAD, WAIT, HALVE, DONE) with 3-bit encoding;
  - the default N and PERIOD localparams;
  - the count_t typedef (logic [N-1:0]).
- Sub-module halflife_prescaler is natural: clear/enable inputs, terminal-count output at PERIOD-1.
  - halflife_ctrl instantiates it once.
- The FSM, target register and command decode stay in halflife_ctrl.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 → all outputs 0 and state IDLE. After rst=1, start is accepted the next cycle.
- Full run, N=4, PERIOD=4, init_val=12, counter model attached:
  - cnt_load pulses once;
  - count sequence is 12→6→3→1→0 with 6, 3, 2 and 1 down pulses respectively;
  - done asserts after the final HALVE;
  - cnt_up is never high.
- init_val=0 → one cnt_load, zero cnt_down, done on the 3rd cycle after start acceptance.
- abort asserted in the 2nd cycle of HALVE with init_val=15 → cnt_down=0 from the next edge, busy=0, IDLE; the counter holds its value.
- start and abort high together in IDLE → stays IDLE, no cnt_load. start during WAIT → ignored, cnt_in unchanged.
- With HALFLIFE_EVENT_CNT_EN, init_val=12 → events=4 at done; a restart clears it to 0 in LOAD.
- Every cycle (assertion): one-hot-or-zero across cnt_up/cnt_down/cnt_load.
